// File: rtl/breakout_game_fsm_if.sv
// Signal bundle between the breakout game sequencer and its surroundings.
// master: event/button source and display sink; slave: the sequencer itself.
interface breakout_game_fsm_if;
    logic        frame_tick;
    logic        btn_start;
    logic        btn_pause;
    logic        brick_hit;
    logic        ball_lost;
    logic        all_cleared;
    logic        pause;
    logic        ball_reset;
    logic        bricks_reset;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [2:0]  state;

    modport master (
        output frame_tick, btn_start, btn_pause, brick_hit, ball_lost, all_cleared,
        input  pause, ball_reset, bricks_reset, score, lives, state
    );

    modport slave (
        input  frame_tick, btn_start, btn_pause, brick_hit, ball_lost, all_cleared,
        output pause, ball_reset, bricks_reset, score, lives, state
    );
endinterface

// File: rtl/breakout_game_fsm.sv
// Breakout game sequencer: idle/serve/play/paused/lost/won FSM with BCD score and lives.
// Optional extra life on every new hundred points: define BREAKOUT_EXTRA_LIFE_EN.
module breakout_game_fsm #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic             clk,
    input  logic             reset,
    breakout_game_fsm_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SERVE  = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_LOST   = 3'd4;
    localparam logic [2:0] ST_WON    = 3'd5;

    localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES);

    // BCD +1 with per-digit carry, saturating at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) begin
            r = v;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        carry       = 1'b1;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4];
                end
            end
        end
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic        pause_q, pause_d;
    logic        ball_reset_q, ball_reset_d;
    logic        bricks_reset_q, bricks_reset_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  serve_q, serve_d;

    logic        btn_start_q, btn_start_h_q;
    logic        btn_pause_q, btn_pause_h_q;
    logic        btn_arm_q;

    logic        start_edge_s;
    logic        pause_edge_s;
    logic [15:0] score_inc_s;
    logic [7:0]  serve_inc_s;
    logic        gain_s;
    logic [1:0]  lives_gain_s;

    // Button sampling; the first cycle after reset seeds both stages so a held button never edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_start_q   <= 1'b0;
            btn_start_h_q <= 1'b0;
            btn_pause_q   <= 1'b0;
            btn_pause_h_q <= 1'b0;
            btn_arm_q     <= 1'b0;
        end else if (!btn_arm_q) begin
            btn_start_q   <= bus.btn_start;
            btn_start_h_q <= bus.btn_start;
            btn_pause_q   <= bus.btn_pause;
            btn_pause_h_q <= bus.btn_pause;
            btn_arm_q     <= 1'b1;
        end else begin
            btn_start_q   <= bus.btn_start;
            btn_start_h_q <= btn_start_q;
            btn_pause_q   <= bus.btn_pause;
            btn_pause_h_q <= btn_pause_q;
            btn_arm_q     <= 1'b1;
        end
    end

    assign start_edge_s = btn_start_q & ~btn_start_h_q;
    assign pause_edge_s = btn_pause_q & ~btn_pause_h_q;
    assign score_inc_s  = bcd_inc(score_q);
    assign serve_inc_s  = serve_q + 8'd1;

`ifdef BREAKOUT_EXTRA_LIFE_EN
    // A hit that rolls the low two digits 99 -> 00 earns a life.
    assign gain_s       = bus.brick_hit & (score_q != 16'h9999) & (score_q[7:0] == 8'h99);
    assign lives_gain_s = gain_s ? ((lives_q == 2'd3) ? 2'd3 : lives_q + 2'd1) : lives_q;
`else
    assign gain_s       = 1'b0;
    assign lives_gain_s = lives_q;
`endif

    // Next-state, score, lives and pulse decisions.
    always_comb begin
        state_d        = state_q;
        score_d        = score_q;
        lives_d        = lives_q;
        serve_d        = serve_q;
        ball_reset_d   = 1'b0;
        bricks_reset_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    lives_d        = LIVES_RST;
                    score_d        = 16'h0000;
                    serve_d        = 8'd0;
                    ball_reset_d   = 1'b1;
                    bricks_reset_d = 1'b1;
                    state_d        = ST_SERVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (serve_inc_s == SERVE_LAST) begin
                        serve_d = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        serve_d = serve_inc_s;
                    end
                end else begin
                    serve_d = serve_q;
                end
            end
            ST_PLAY: begin
                if (bus.brick_hit) begin
                    score_d = score_inc_s;
                end else begin
                    score_d = score_q;
                end
                // A life earned in the same cycle as a lost ball cancels the loss.
                if (bus.all_cleared) begin
                    lives_d = lives_gain_s;
                    state_d = ST_WON;
                end else if (bus.ball_lost) begin
                    if (gain_s) begin
                        lives_d      = lives_q;
                        ball_reset_d = 1'b1;
                        serve_d      = 8'd0;
                        state_d      = ST_SERVE;
                    end else if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_LOST;
                    end else begin
                        lives_d      = lives_q - 2'd1;
                        ball_reset_d = 1'b1;
                        serve_d      = 8'd0;
                        state_d      = ST_SERVE;
                    end
                end else if (pause_edge_s) begin
                    lives_d = lives_gain_s;
                    state_d = ST_PAUSED;
                end else begin
                    lives_d = lives_gain_s;
                end
            end
            ST_PAUSED: begin
                if (pause_edge_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_LOST, ST_WON: begin
                if (start_edge_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pause_d = (state_d != ST_PLAY);
    end

    // Game state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pause_q        <= 1'b1;
            ball_reset_q   <= 1'b0;
            bricks_reset_q <= 1'b0;
            score_q        <= 16'h0000;
            lives_q        <= LIVES_RST;
            serve_q        <= 8'd0;
        end else begin
            state_q        <= state_d;
            pause_q        <= pause_d;
            ball_reset_q   <= ball_reset_d;
            bricks_reset_q <= bricks_reset_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            serve_q        <= serve_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.pause        = pause_q;
    assign bus.ball_reset   = ball_reset_q;
    assign bus.bricks_reset = bricks_reset_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;

endmodule

// File: tb/tb_breakout_game_fsm.sv
// Randomized and directed bench for breakout_game_fsm against a decimal-score behavioural model.
module tb_breakout_game_fsm;
    localparam int LI = 3;
    localparam int SF = 60;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    breakout_game_fsm_if bus();

    breakout_game_fsm #(.LIVES_INIT(LI), .SERVE_FRAMES(SF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: game state as plain integers, score kept in decimal.
    int m_state, m_score, m_lives, m_serve, npost;
    bit m_br, m_kr;
    bit s1, s2, p1, p2;
    bit cmp_en = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", int'(bus.state), m_state);
            chk("pause", int'(bus.pause), (m_state != 2) ? 1 : 0);
            chk("ball_reset", int'(bus.ball_reset), int'(m_br));
            chk("bricks_reset", int'(bus.bricks_reset), int'(m_kr));
            chk("score", int'(bus.score), int'(to_bcd(m_score)));
            chk("lives", int'(bus.lives), m_lives);
        end
    end

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = LI; m_serve = 0;
        m_br = 1'b0; m_kr = 1'b0;
        s1 = 1'b0; s2 = 1'b0; p1 = 1'b0; p2 = 1'b0; npost = 0;
    endtask

    task automatic model_step();
        bit se, pe, gain;
        se   = (npost >= 2) && s1 && !s2;
        pe   = (npost >= 2) && p1 && !p2;
        gain = 1'b0;
        m_br = 1'b0;
        m_kr = 1'b0;
        case (m_state)
            0: if (se) begin
                m_lives = LI; m_score = 0; m_serve = 0;
                m_br = 1'b1; m_kr = 1'b1; m_state = 1;
            end
            1: if (bus.frame_tick) begin
                m_serve++;
                if (m_serve == SF) begin m_serve = 0; m_state = 2; end
            end
            2: begin
                if (bus.brick_hit && m_score < 9999) begin
`ifdef BREAKOUT_EXTRA_LIFE_EN
                    gain = (m_score % 100 == 99);
`endif
                    m_score++;
                end
                if (bus.all_cleared) begin
                    m_state = 5;
                    if (gain && m_lives < 3) m_lives++;
                end else if (bus.ball_lost) begin
                    if (gain || m_lives > 1) begin
                        if (!gain) m_lives--;
                        m_br = 1'b1; m_serve = 0; m_state = 1;
                    end else begin
                        m_lives = 0; m_state = 4;
                    end
                end else begin
                    if (gain && m_lives < 3) m_lives++;
                    if (pe) m_state = 3;
                end
            end
            3: if (pe) m_state = 2;
            default: if (se) m_state = 0;
        endcase
        s2 = s1; s1 = bus.btn_start;
        p2 = p1; p1 = bus.btn_pause;
        if (npost < 2) npost++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit ft, input bit bs, input bit bp,
                        input bit bh, input bit bl, input bit ac);
        bus.frame_tick  = ft;
        bus.btn_start   = bs;
        bus.btn_pause   = bp;
        bus.brick_hit   = bh;
        bus.ball_lost   = bl;
        bus.all_cleared = ac;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit bs);
        #2;
        reset = 1'b0;
        bus.frame_tick = 1'b0; bus.btn_start = bs; bus.btn_pause = 1'b0;
        bus.brick_hit = 1'b0; bus.ball_lost = 1'b0; bus.all_cleared = 1'b0;
        model_reset();
        #1;
        chk("async_reset_state", int'(bus.state), 0);
        chk("async_reset_pulse", int'(bus.ball_reset | bus.bricks_reset), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic start_game();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
        chk("start_game_play", int'(bus.state), 2);
    endtask

    initial begin
        int nb, nk;
        bit bs, bp;
        reset = 1'b0;
        bus.frame_tick = 1'b0; bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
        bus.brick_hit = 1'b0; bus.ball_lost = 1'b0; bus.all_cleared = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pause", int'(bus.pause), 1);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_lives", int'(bus.lives), 3);
        chk("rst_pulses", int'(bus.ball_reset | bus.bricks_reset), 0);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Start held for 5 cycles: one pulse of each, then a 60-tick serve.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        nb = 0; nk = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 0);
            nb += int'(bus.ball_reset);
            nk += int'(bus.bricks_reset);
        end
        chk("start_ball_pulses", nb, 1);
        chk("start_brick_pulses", nk, 1);
        chk("start_state_serve", int'(bus.state), 1);
        chk("start_lives", int'(bus.lives), 3);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SF - 1; i++) step(1, 0, 0, 0, 0, 0);
        chk("serve_not_yet", int'(bus.state), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("serve_done_state", int'(bus.state), 2);
        chk("serve_done_pause", int'(bus.pause), 0);

        for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0, 0);
        chk("score_11", int'(bus.score), 16'h0011);

        // Saturation at 9999.
        do_reset(1'b0);
        start_game();
        for (int i = 0; i < 10000; i++) step(0, 0, 0, 1, 0, 0);
        chk("score_sat", int'(bus.score), 16'h9999);

        // Last life lost.
        do_reset(1'b0);
        start_game();
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 1, 0);
            for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
        end
        chk("lives_one", int'(bus.lives), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("lost_state", int'(bus.state), 4);
        chk("lost_lives", int'(bus.lives), 0);
        chk("lost_pause", int'(bus.pause), 1);
        chk("lost_no_ball_reset", int'(bus.ball_reset), 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("lost_to_idle", int'(bus.state), 0);

        // Cleared wins over a simultaneous lost ball; hit still scores.
        do_reset(1'b0);
        start_game();
        step(0, 0, 0, 1, 1, 1);
        chk("won_state", int'(bus.state), 5);
        chk("won_lives", int'(bus.lives), 3);
        chk("won_score", int'(bus.score), 16'h0001);

        // Pause and resume.
        do_reset(1'b0);
        start_game();
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("paused_state", int'(bus.state), 3);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("paused_score", int'(bus.score), 0);
        chk("paused_lives", int'(bus.lives), 3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("resume_state", int'(bus.state), 2);

`ifdef BREAKOUT_EXTRA_LIFE_EN
        do_reset(1'b0);
        start_game();
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 99; i++) step(0, 0, 0, 1, 0, 0);
        chk("xl_score_99", int'(bus.score), 16'h0099);
        chk("xl_lives_2", int'(bus.lives), 2);
        step(0, 0, 0, 1, 0, 0);
        chk("xl_score_100", int'(bus.score), 16'h0100);
        chk("xl_lives_3", int'(bus.lives), 3);
        for (int i = 0; i < 99; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("xl_score_200", int'(bus.score), 16'h0200);
        chk("xl_lives_sat", int'(bus.lives), 3);
`endif

        // Reset mid-game with start held: no edge afterwards.
        start_game();
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
        chk("held_start_idle", int'(bus.state), 0);

        // Randomized play.
        bs = 1'b0; bp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) bs = ~bs;
            if ($urandom_range(0, 24) == 0) bp = ~bp;
            step($urandom_range(0, 3) == 0, bs, bp,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 149) == 0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
